// File: rtl/load_store_unit.sv
// load_store_unit: RV64 load/store initiator for an 8-byte-aligned data memory.
// Sub-doubleword stores are read-modify-write. Loads are extracted from the
// doubleword and then sign- or zero-extended. Misaligned, out-of-range or
// illegal requests fault without touching memory.
// Optional feature macro: LSU_SD_BYPASS_EN. When it is defined, an aligned SD
// skips the read and writes req_wdata directly.
module load_store_unit #(
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        mem_write_en,
  output logic        mem_read_en,
  input  logic [63:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  off_reg;
  logic [2:0]  funct3_reg;
  logic        write_reg;
  logic [63:0] wdata_reg;
  logic [63:0] resp_rdata_reg;
  logic        resp_fault_reg;
  logic [63:0] mem_address_reg;
  logic [63:0] mem_write_data_reg;

  logic        accept;
  logic [2:0]  align_mask;
  logic        req_fault;
  logic        req_sd_bypass;
  logic [7:0]  size_lanes;
  logic [7:0]  lane_mask;
  logic [63:0] wdata_shift;
  logic [63:0] merged_word;
  logic [63:0] rd_shift;
  logic [63:0] load_ext;
  logic        sign_ext;

  assign accept = req_valid && (state_reg == IDLE);

  // Decode alignment, range and legality of the incoming request
  always_comb begin
    align_mask = 3'b000;
    case (req_funct3[1:0])
      2'b00:   align_mask = 3'b000;
      2'b01:   align_mask = 3'b001;
      2'b10:   align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    req_fault = (|(req_addr[2:0] & align_mask))
             || (|req_addr[63:MEM_ADDR_BITS])
             || (req_funct3 == 3'b111)
             || (req_write && req_funct3[2]);
  end

`ifdef LSU_SD_BYPASS_EN
  // A full doubleword store has no untouched lanes, so it needs no old word
  assign req_sd_bypass = req_write && (req_funct3 == 3'b011);
`else
  assign req_sd_bypass = 1'b0;
`endif

  // Store lane selection and load extraction from the captured request
  always_comb begin
    size_lanes = 8'h01;
    case (funct3_reg[1:0])
      2'b00:   size_lanes = 8'h01;
      2'b01:   size_lanes = 8'h03;
      2'b10:   size_lanes = 8'h0F;
      default: size_lanes = 8'hFF;
    endcase
    lane_mask   = size_lanes << off_reg;
    wdata_shift = wdata_reg << {off_reg, 3'b000};
    rd_shift    = mem_read_data >> {off_reg, 3'b000};
    sign_ext    = ~funct3_reg[2];
    load_ext    = rd_shift;
    case (funct3_reg[1:0])
      2'b00:   load_ext = {{56{sign_ext & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   load_ext = {{48{sign_ext & rd_shift[15]}}, rd_shift[15:0]};
      2'b10:   load_ext = {{32{sign_ext & rd_shift[31]}}, rd_shift[31:0]};
      default: load_ext = rd_shift;
    endcase
  end

  // Per byte lane: new store byte where selected, old memory byte elsewhere
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = lane_mask[gi] ? wdata_shift[8*gi +: 8]
                                                    : mem_read_data[8*gi +: 8];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_fault)          state_next = RESP;
          else if (req_sd_bypass) state_next = WRITE;
          else                    state_next = READ;
        end
      end
      READ:    state_next = write_reg ? WRITE : RESP;
      WRITE:   state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, merge/extract registers and response data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      off_reg            <= 3'b000;
      funct3_reg         <= 3'b000;
      write_reg          <= 1'b0;
      wdata_reg          <= 64'd0;
      resp_rdata_reg     <= 64'd0;
      resp_fault_reg     <= 1'b0;
      mem_address_reg    <= 64'd0;
      mem_write_data_reg <= 64'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            off_reg         <= req_addr[2:0];
            funct3_reg      <= req_funct3;
            write_reg       <= req_write;
            wdata_reg       <= req_wdata;
            mem_address_reg <= {req_addr[63:3], 3'b000};
            if (req_fault) begin
              resp_rdata_reg <= 64'd0;
              resp_fault_reg <= 1'b1;
            end else if (req_sd_bypass) begin
              mem_write_data_reg <= req_wdata;
            end
          end
        end
        READ: begin
          if (write_reg) begin
            mem_write_data_reg <= merged_word;
          end else begin
            resp_rdata_reg <= load_ext;
            resp_fault_reg <= 1'b0;
          end
        end
        WRITE: begin
          resp_rdata_reg <= 64'd0;
          resp_fault_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registers
  always_comb begin
    req_ready      = (state_reg == IDLE);
    mem_read_en    = (state_reg == READ);
    mem_write_en   = (state_reg == WRITE);
    resp_valid     = (state_reg == RESP);
    resp_rdata     = resp_rdata_reg;
    resp_fault     = resp_fault_reg;
    mem_address    = mem_address_reg;
    mem_write_data = mem_write_data_reg;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven checks of load_store_unit against a
// 128-doubleword memory model, plus sequences for a reset during a write and
// for back-to-back requests.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [63:0] mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_ADDR_BITS(10)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_fault     (resp_fault),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_en    (mem_read_en),
    .mem_read_data  (mem_read_data)
  );

  // Memory model: combinational read, write at posedge
  logic [63:0] dm [128];
  logic        mem_clear;
  assign mem_read_data = dm[mem_address[9:3]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 128; i++) dm[i] <= 64'd0;
      dm[0] <= 64'd1;
      dm[1] <= 64'd2;
    end else if (mem_write_en) begin
      dm[mem_address[9:3]] <= mem_write_data;
    end
  end

  // Activity monitors
  int rd_cnt = 0;
  int wr_cnt = 0;
  int cyc    = 0;
  logic [63:0] resp_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read_en)  rd_cnt <= rd_cnt + 1;
    if (mem_write_en) wr_cnt <= wr_cnt + 1;
  end

  always @(negedge clk) begin
    if (resp_valid) resp_q.push_back(resp_rdata);
  end

`ifdef LSU_SD_BYPASS_EN
  localparam int SD_LAT = 2;
  localparam int SD_NR  = 0;
`else
  localparam int SD_LAT = 3;
  localparam int SD_NR  = 1;
`endif

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    int          exp_nr;
    int          exp_nw;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] er, input logic ef,
                              input int lat, input int nr, input int nw);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_fault = ef; v.exp_lat = lat; v.exp_nr = nr; v.exp_nw = nw;
    return v;
  endfunction

  // Issue one request and measure latency and memory activity
  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, output logic [63:0] rdata,
                         output logic fault, output int lat, output int nr, output int nw);
    int rc0, wc0;
    @(negedge clk);
    for (int k = 0; k < 10 && !req_ready; k++) @(negedge clk);
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    rc0 = rd_cnt;
    wc0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat   = -1;
    rdata = 'x;
    fault = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat   = k;
        rdata = resp_rdata;
        fault = resp_fault;
        break;
      end
    end
    nr = rd_cnt - rc0;
    nw = wr_cnt - wc0;
  endtask

  logic [63:0] got_rdata;
  logic        got_fault;
  int          got_lat, got_nr, got_nw;
  int          rq0, wc_snap;
  int          acc_cyc [4];
  logic [63:0] b2b_addr [4];
  logic [63:0] b2b_exp  [4];
  bit          got;

  initial begin
    vecs[0]  = mk(1'b0, 3'b011, 64'h8,   64'h0,    64'h2,                  1'b0, 2, 1, 0);
    vecs[1]  = mk(1'b1, 3'b000, 64'h3,   64'hFF,   64'h0,                  1'b0, 3, 1, 1);
    vecs[2]  = mk(1'b0, 3'b011, 64'h0,   64'h0,    64'h00000000FF000001,   1'b0, 2, 1, 0);
    vecs[3]  = mk(1'b0, 3'b000, 64'h3,   64'h0,    64'hFFFFFFFFFFFFFFFF,   1'b0, 2, 1, 0);
    vecs[4]  = mk(1'b0, 3'b100, 64'h3,   64'h0,    64'hFF,                 1'b0, 2, 1, 0);
    vecs[5]  = mk(1'b1, 3'b001, 64'h5,   64'h1234, 64'h0,                  1'b1, 1, 0, 0);
    vecs[6]  = mk(1'b0, 3'b010, 64'h6,   64'h0,    64'h0,                  1'b1, 1, 0, 0);
    vecs[7]  = mk(1'b0, 3'b011, 64'h400, 64'h0,    64'h0,                  1'b1, 1, 0, 0);
    vecs[8]  = mk(1'b0, 3'b111, 64'h8,   64'h0,    64'h0,                  1'b1, 1, 0, 0);
    vecs[9]  = mk(1'b1, 3'b011, 64'h10,  64'h1122334455667788, 64'h0,     1'b0, SD_LAT, SD_NR, 1);
    vecs[10] = mk(1'b0, 3'b011, 64'h10,  64'h0,    64'h1122334455667788,   1'b0, 2, 1, 0);
    vecs[11] = mk(1'b0, 3'b001, 64'h12,  64'h0,    64'h5566,               1'b0, 2, 1, 0);
    vecs[12] = mk(1'b0, 3'b010, 64'h14,  64'h0,    64'h11223344,           1'b0, 2, 1, 0);
    vecs[13] = mk(1'b1, 3'b001, 64'h16,  64'hBEEF, 64'h0,                  1'b0, 3, 1, 1);
    vecs[14] = mk(1'b0, 3'b001, 64'h16,  64'h0,    64'hFFFFFFFFFFFFBEEF,   1'b0, 2, 1, 0);
    vecs[15] = mk(1'b0, 3'b101, 64'h16,  64'h0,    64'hBEEF,               1'b0, 2, 1, 0);
    vecs[16] = mk(1'b0, 3'b010, 64'h14,  64'h0,    64'hFFFFFFFFBEEF3344,   1'b0, 2, 1, 0);
    vecs[17] = mk(1'b0, 3'b110, 64'h14,  64'h0,    64'hBEEF3344,           1'b0, 2, 1, 0);
    vecs[18] = mk(1'b1, 3'b110, 64'h8,   64'h5,    64'h0,                  1'b1, 1, 0, 0);
    vecs[19] = mk(1'b0, 3'b011, 64'h10,  64'h0,    64'hBEEF334455667788,   1'b0, 2, 1, 0);
    vecs[20] = mk(1'b1, 3'b000, 64'h7,   64'hABCD, 64'h0,                  1'b0, 3, 1, 1);
    vecs[21] = mk(1'b0, 3'b000, 64'h7,   64'h0,    64'hFFFFFFFFFFFFFFCD,   1'b0, 2, 1, 0);
    vecs[22] = mk(1'b0, 3'b011, 64'h3F8, 64'h0,    64'h0,                  1'b0, 2, 1, 0);
    vecs[23] = mk(1'b1, 3'b011, 64'hC,   64'h99,   64'h0,                  1'b1, 1, 0, 0);

    // Reset with memory initialisation
    rstn = 1'b0; mem_clear = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 64'd0; req_wdata = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready",   {63'd0, req_ready},    64'd1);
    check("reset_resp_valid",  {63'd0, resp_valid},   64'd0);
    check("reset_mem_read_en", {63'd0, mem_read_en},  64'd0);
    check("reset_mem_write_en",{63'd0, mem_write_en}, 64'd0);
    check("reset_resp_rdata",  resp_rdata,            64'd0);
    check("reset_mem_address", mem_address,           64'd0);
    rstn = 1'b1; mem_clear = 1'b0;

    // Table-driven requests
    for (int i = 0; i < NVEC; i++) begin
      run_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
              got_rdata, got_fault, got_lat, got_nr, got_nw);
      $display("[TB] vec %0d wr=%0b f3=%0d addr=%h wdata=%h -> rdata=%h fault=%0b lat=%0d reads=%0d writes=%0d",
               i, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
               got_rdata, got_fault, got_lat, got_nr, got_nw);
      check($sformatf("vec%0d_rdata", i),  got_rdata,                vecs[i].exp_rdata);
      check($sformatf("vec%0d_fault", i),  {63'd0, got_fault},       {63'd0, vecs[i].exp_fault});
      check($sformatf("vec%0d_latency", i), 64'(got_lat),            64'(vecs[i].exp_lat));
      check($sformatf("vec%0d_reads", i),  64'(got_nr),              64'(vecs[i].exp_nr));
      check($sformatf("vec%0d_writes", i), 64'(got_nw),              64'(vecs[i].exp_nw));
    end
    check("dm0_after_stores", dm[0], 64'hCD000000FF000001);
    check("dm2_after_stores", dm[2], 64'hBEEF334455667788);

    // Reset during the WRITE cycle of SW @0x0 must suppress the write
    @(negedge clk);
    mem_clear = 1'b1;
    @(posedge clk);
    #1 mem_clear = 1'b0;
    rq0 = resp_q.size();
    wc_snap = wr_cnt;
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'b010; req_addr = 64'h0;
    req_wdata = 64'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_seq_read_cycle", {63'd0, mem_read_en}, 64'd1);
    @(posedge clk);
    #1;
    check("rst_seq_write_cycle", {63'd0, mem_write_en}, 64'd1);
    rstn = 1'b0;
    #1;
    check("rst_seq_write_dropped", {63'd0, mem_write_en}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    $display("[TB] reset-during-write: dm0=%h writes=%0d resps=%0d ready=%0b",
             dm[0], wr_cnt - wc_snap, resp_q.size() - rq0, req_ready);
    check("rst_seq_dm0",        dm[0],                          64'd1);
    check("rst_seq_no_write",   64'(wr_cnt - wc_snap),          64'd0);
    check("rst_seq_no_resp",    64'(resp_q.size() - rq0),       64'd0);
    check("rst_seq_req_ready",  {63'd0, req_ready},             64'd1);

    // req_valid held high for four loads: accepts only in IDLE, in order
    b2b_addr[0] = 64'h8;  b2b_exp[0] = 64'h2;
    b2b_addr[1] = 64'h0;  b2b_exp[1] = 64'h1;
    b2b_addr[2] = 64'h10; b2b_exp[2] = 64'h0;
    b2b_addr[3] = 64'h8;  b2b_exp[3] = 64'h2;
    rq0 = resp_q.size();
    @(negedge clk);
    req_write = 1'b0; req_funct3 = 3'b011; req_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      req_addr = b2b_addr[n];
      got = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (k > 0 || n > 0) @(negedge clk);
        if (req_ready) begin got = 1'b1; break; end
      end
      check($sformatf("b2b_ready%0d", n), {63'd0, got}, 64'd1);
      @(posedge clk);
      #1 acc_cyc[n] = cyc;
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_resp_count", 64'(resp_q.size() - rq0), 64'd4);
    for (int n = 0; n < 4; n++) begin
      if (resp_q.size() > rq0 + n) begin
        $display("[TB] b2b load %0d addr=%h rdata=%h", n, b2b_addr[n], resp_q[rq0 + n]);
        check($sformatf("b2b_rdata%0d", n), resp_q[rq0 + n], b2b_exp[n]);
      end
      if (n > 0) check($sformatf("b2b_gap%0d", n), 64'(acc_cyc[n] - acc_cyc[n-1]), 64'd3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
